pack_i32_stream: RTL and testbench

PACK_I32_STREAM -- requirements
Module: pack_i32_stream

---
 rtl/leb128_pkg.sv | 12 +
 rtl/pack_i32_stream_if.sv | 22 ++
 rtl/leb128_enc_step.sv | 32 +++
 rtl/pack_i32_stream.sv | 84 ++++++++
 tb/tb_pack_i32_stream.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/leb128_pkg.sv
// Shared constants and state encoding for the 32-bit LEB128 stream packer.
package leb128_pkg;

    localparam int GROUP_BITS    = 7;
    localparam int MAX_BYTES_I32 = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/pack_i32_stream_if.sv
// Word-in / byte-out handshake bundle; the packer is the slave, its environment the master.
interface pack_i32_stream_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/leb128_enc_step.sv
// One LEB128 group step: emits the byte for the current remaining value and the value after it.
module leb128_enc_step
    import leb128_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic [31:0] value_i,
    input  logic [2:0]  idx_i,
    output logic [7:0]  byte_o,
    output logic        last_o,
    output logic [31:0] next_o
);

    logic [GROUP_BITS-1:0] grp;
    logic                  term;

    always_comb begin
        grp = value_i[GROUP_BITS-1:0];
        if (SIGNED) begin
            next_o = $signed(value_i) >>> GROUP_BITS;
            // Stop once the remaining bits are pure sign extension of the group's top bit.
            term = ((next_o == '0) && !grp[GROUP_BITS-1]) ||
                   ((next_o == '1) &&  grp[GROUP_BITS-1]);
        end else begin
            next_o = value_i >> GROUP_BITS;
            term   = (next_o == '0);
        end
        last_o = term || (idx_i == 3'(MAX_BYTES_I32 - 1));
        byte_o = {~last_o, grp};
    end

endmodule

// File: rtl/pack_i32_stream.sv
// Accepts 32-bit words and streams them out as LEB128 bytes, one byte per cycle.
module pack_i32_stream
    import leb128_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    pack_i32_stream_if.slave   s
);

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic [2:0]  idx_q, idx_d;

    logic [7:0]  enc_byte;
    logic        enc_last;
    logic [31:0] enc_next;
    logic        load;

    leb128_enc_step #(.SIGNED(SIGNED)) u_step (
        .value_i (val_q),
        .idx_i   (idx_q),
        .byte_o  (enc_byte),
        .last_o  (enc_last),
        .next_o  (enc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        idx_d       = idx_q;
        load        = 1'b0;
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                s.in_ready = 1'b1;
                if (s.in_valid) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                s.out_valid = 1'b1;
                // A new word may enter only as the final byte leaves, so there is no bubble.
                s.in_ready  = s.out_ready & enc_last;
                if (s.out_ready) begin
                    if (enc_last) begin
                        if (s.in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        val_d = enc_next;
                        idx_d = 3'(idx_q + 3'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            val_d = s.in_data;
            idx_d = '0;
        end
    end

    assign s.out_data = (state_q == SEND) ? enc_byte : 8'h00;
    assign s.out_last = (state_q == SEND) && enc_last;

endmodule

// File: tb/tb_pack_i32_stream.sv
// Directed bench for pack_i32_stream: signed and unsigned instances, hand-computed byte streams.
module tb_pack_i32_stream;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pack_i32_stream_if s_if ();
    pack_i32_stream_if u_if ();

    pack_i32_stream #(.SIGNED(1'b1)) dut_s (.clk(clk), .reset_n(reset_n), .s(s_if.slave));
    pack_i32_stream #(.SIGNED(1'b0)) dut_u (.clk(clk), .reset_n(reset_n), .s(u_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       sel_u;
    logic       ov, ol, ir;
    logic [7:0] od;
    assign ov = sel_u ? u_if.out_valid : s_if.out_valid;
    assign ol = sel_u ? u_if.out_last  : s_if.out_last;
    assign ir = sel_u ? u_if.in_ready  : s_if.in_ready;
    assign od = sel_u ? u_if.out_data  : s_if.out_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [31:0] d);
        if (sel_u) begin
            u_if.in_valid = v;
            u_if.in_data  = d;
        end else begin
            s_if.in_valid = v;
            s_if.in_data  = d;
        end
    endtask

    task automatic drive_ordy(input logic r);
        if (sel_u) u_if.out_ready = r;
        else       s_if.out_ready = r;
    endtask

    // exp holds byte k at bits [8k+7:8k]; stall = cycles of out_ready low before each byte.
    task automatic encode(input string name, input logic uns, input logic [31:0] w,
                          input logic [39:0] exp, input int n, input int stall);
        logic [7:0] eb;
        sel_u = uns;
        @(negedge clk);
        drive_in(1'b1, w);
        drive_ordy(1'b0);
        check_eq({name, ".acc_rdy"}, 32'(ir), 32'd1);
        @(negedge clk);
        drive_in(1'b0, ~w);
        for (int k = 0; k < n; k++) begin
            eb = exp[8*k +: 8];
            for (int st = 0; st < stall; st++) begin
                drive_ordy(1'b0);
                check_eq($sformatf("%s.stall%0d.b%0d", name, st, k), {23'd0, ov, ol, od},
                         {23'd0, 1'b1, 1'(k == n - 1), eb});
                @(negedge clk);
            end
            drive_ordy(1'b1);
            check_eq($sformatf("%s.b%0d", name, k), {23'd0, ov, ol, od},
                     {23'd0, 1'b1, 1'(k == n - 1), eb});
            @(negedge clk);
        end
        drive_ordy(1'b0);
        check_eq({name, ".idle"}, 32'(ov), 32'd0);
    endtask

    initial begin
        sel_u   = 1'b0;
        reset_n = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b0;
        u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.out_ready = 1'b0;

        #2;
        check_eq("rst.s", {20'd0, s_if.out_valid, s_if.out_last, s_if.in_ready, 1'b0, s_if.out_data},
                 {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        check_eq("rst.u", {20'd0, u_if.out_valid, u_if.out_last, u_if.in_ready, 1'b0, u_if.out_data},
                 {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        encode("zero",    1'b0, 32'h0000_0000, 40'h00,           1, 0);
        encode("p63",     1'b0, 32'd63,        40'h3F,           1, 0);
        encode("p64",     1'b0, 32'd64,        40'h00C0,         2, 0);
        encode("u64",     1'b1, 32'd64,        40'h40,           1, 0);
        encode("m1",      1'b0, 32'hFFFF_FFFF, 40'h7F,           1, 0);
        encode("m64",     1'b0, 32'hFFFF_FFC0, 40'h40,           1, 0);
        encode("m65",     1'b0, 32'hFFFF_FFBF, 40'h7FBF,         2, 0);
        encode("maxpos",  1'b0, 32'h7FFF_FFFF, 40'h07FFFFFFFF,   5, 0);
        encode("minneg",  1'b0, 32'h8000_0000, 40'h7880808080,   5, 0);
        encode("umax",    1'b1, 32'hFFFF_FFFF, 40'h0FFFFFFFFF,   5, 0);
        encode("bp",      1'b0, 32'h0001_2345, 40'h04C6C5,       3, 3);

        // Back-to-back: 128 then 1, no idle cycle between words.
        sel_u = 1'b0;
        @(negedge clk);
        s_if.in_valid = 1'b1; s_if.in_data = 32'd128; s_if.out_ready = 1'b1;
        @(negedge clk);
        s_if.in_data = 32'd1;
        check_eq("b2b.b0", {22'd0, s_if.out_valid, s_if.out_last, s_if.in_ready, s_if.out_data},
                 {22'd0, 1'b1, 1'b0, 1'b0, 8'h80});
        @(negedge clk);
        check_eq("b2b.b1", {22'd0, s_if.out_valid, s_if.out_last, s_if.in_ready, s_if.out_data},
                 {22'd0, 1'b1, 1'b1, 1'b1, 8'h01});
        @(negedge clk);
        s_if.in_valid = 1'b0;
        check_eq("b2b.w2", {23'd0, s_if.out_valid, s_if.out_last, s_if.out_data},
                 {23'd0, 1'b1, 1'b1, 8'h01});
        @(negedge clk);
        s_if.out_ready = 1'b0;
        check_eq("b2b.idle", 32'(s_if.out_valid), 32'd0);

        // Reset mid-word aborts the remainder of 0x7FFFFFFF.
        @(negedge clk);
        s_if.in_valid = 1'b1; s_if.in_data = 32'h7FFF_FFFF;
        @(negedge clk);
        s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
        check_eq("rmid.b0", 32'(s_if.out_data), 32'hFF);
        @(negedge clk);
        s_if.out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("rmid.ov", {30'd0, s_if.out_valid, s_if.in_ready}, {30'd0, 1'b0, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rmid.quiet", 32'(s_if.out_valid), 32'd0);
        encode("after", 1'b0, 32'd5, 40'h05, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
